softmax_row_scheduler: RTL and testbench
========================================

Name: softmax_row_scheduler

Overview:
- Shares one softmax unit between NUM_REQ requesters (e.g. attention heads draining systolic-array rows) using round-robin arbitration.
- The granted requester owns the unit for a whole job of N rows.
- For each row, the block drives the softmax enable level for exactly ROW_CYCLES cycles, then drops it for GAP_CYCLES cycles so the softmax controller's stage counter and FSM return to IDLE before the next row.
- It publishes per-row and per-job strobes back to the requesters.

Parameters:
- NUM_REQ, 2, number of requesters (2..8).
- ROWS_W, 8, width of a per-job row count.
- ROW_CYCLES, 26, cycles softmax_en is held high per row (full stage1..stage4 pass).
- GAP_CYCLES, 1, cycles softmax_en is held low between rows of one job; must be >=1.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- req  input  NUM_REQ  per-requester job request level.
- req_rows  input  NUM_REQ*ROWS_W  row count per requester; slice i = [i*ROWS_W +: ROWS_W].
- grant  output  NUM_REQ  one-hot owner of the softmax unit, registered.
- softmax_en  output  1  enable level to the softmax controller, registered.
- row_start  output  1  one-cycle pulse on the first softmax_en cycle of each row.
- row_done  output  1  one-cycle pulse on the last softmax_en cycle of each row.
- row_idx  output  ROWS_W  index of the current row within the job (0-based).
- job_done  output  NUM_REQ  one-cycle pulse to the owning requester when its job ends.
- busy  output  1  high while state != IDLE.

Behaviour:
- Reset (synchronous, active-high):
  - state=IDLE; all outputs 0; run/gap counters 0.
  - Round-robin pointer set so requester 0 has highest priority.
  - Reset mid-job aborts immediately: the next cycle has softmax_en=0 and grant=0, and no job_done is issued.
- FSM states: IDLE, RUN, GAP.
- IDLE:
  - If any req bit is set, select the winner by scanning from (last_winner+1) mod NUM_REQ upward.
  - Latch the winner's req_rows and update last_winner.
  - If latched rows != 0: the next cycle is RUN with grant=onehot(winner), row_idx=0, softmax_en=1, row_start=1.
  - If rows == 0: stay IDLE, pulse job_done[winner] the next cycle, grant stays 0, pointer still advances.
- RUN:
  - softmax_en=1 for ROW_CYCLES consecutive cycles, with run counter 0..ROW_CYCLES-1.
  - row_start is high on counter 0; row_done is high on counter ROW_CYCLES-1.
  - At the last cycle, if row_idx == rows-1: job_done[owner] is asserted in that same cycle, and the next cycle is IDLE with grant=0, softmax_en=0, row_idx=0.
  - Otherwise the next state is GAP.
- GAP:
  - softmax_en=0 for GAP_CYCLES cycles; grant is held.
  - row_idx increments on GAP entry.
  - Then RUN, with row_start on its first cycle.
- Inter-job spacing: every job exit spends at least 1 IDLE cycle, so softmax_en is low for >=1 cycle between jobs.
- Requester rules:
  - req and req_rows are sampled only in IDLE.
  - Deasserting req mid-job is ignored; the job completes.
  - A requester must drop req on or after job_done, otherwise it re-enters arbitration.
- Mutual exclusion: grant is one-hot or zero, never multi-hot; job_done is never asserted for a non-owner.
- Row boundary: rows = 2^ROWS_W-1 is legal; the comparison rows-1 is done in ROWS_W bits with no wrap (rows=0 is handled in IDLE).
- Counter widths: the run counter is clog2(ROW_CYCLES) bits and the gap counter clog2(GAP_CYCLES+1) bits; neither wraps beyond its terminal value.
- Latency: req seen in IDLE at cycle t gives grant and softmax_en at t+1. One row costs ROW_CYCLES+GAP_CYCLES cycles, except the last row, which costs ROW_CYCLES.

Test Plan:
1. Single job, 3 rows (req[0]=1, rows=3 at cycle 0, defaults) -> softmax_en high on cycles 1-26, 28-53, 55-80 and low on 27 and 54; row_start at 1/28/55; row_done at 26/53/80; job_done[0] at 80; grant=01 on cycles 1-80; busy low at 81.
2. Contention (req=11, rows0=1, rows1=1 at cycle 0, held until job_done) -> req0 granted cycles 1-26; IDLE at 27; req1 granted cycles 28-53; after req0 re-asserts, req0 regains grant at 55 (round-robin, never twice in a row under contention).
3. Zero-row job (req[1]=1, rows=0) -> job_done[1] pulse at cycle 1; grant and softmax_en stay 0; busy stays 0; the pointer advances so req0 wins next contention.
4. Reset mid-job (rows=2, rst high at cycle 10) -> cycle 11 has all outputs 0 and state IDLE, with no job_done; re-request at cycle 12 gives grant to req0 at 13.
5. req dropped mid-job (req[0] low at cycle 5, rows=2) -> job still runs to completion, with job_done[0] at cycle 53.
6. GAP_CYCLES=3, rows=2 -> softmax_en low on cycles 27-29; second row runs on cycles 30-55; row_idx=1 from cycle 27.

Source files
------------

// File: rtl/softmax_row_scheduler.sv
// Round-robin scheduler sharing one softmax unit between NUM_REQ requesters.
// Each granted requester owns the unit for a whole job of N rows.
// Every row holds softmax_en high for ROW_CYCLES cycles, then low for
// GAP_CYCLES cycles so the softmax controller returns to IDLE.
// Ports:
//   clk, rst        : clock, synchronous active-high reset
//   req, req_rows   : per-requester request level and row count
//   grant           : one-hot owner, registered
//   softmax_en      : enable level to the softmax controller
//   row_start/done  : first/last enable cycle of each row
//   row_idx         : 0-based row within the job
//   job_done        : end-of-job pulse to the owner
//   busy            : high while not IDLE
module softmax_row_scheduler #(
  parameter int NUM_REQ    = 2,
  parameter int ROWS_W     = 8,
  parameter int ROW_CYCLES = 26,
  parameter int GAP_CYCLES = 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_REQ-1:0]         req,
  input  logic [NUM_REQ*ROWS_W-1:0]  req_rows,
  output logic [NUM_REQ-1:0]         grant,
  output logic                       softmax_en,
  output logic                       row_start,
  output logic                       row_done,
  output logic [ROWS_W-1:0]          row_idx,
  output logic [NUM_REQ-1:0]         job_done,
  output logic                       busy
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int RUN_W = (ROW_CYCLES > 1) ? $clog2(ROW_CYCLES) : 1;
  localparam int GAP_W = $clog2(GAP_CYCLES + 1);

  localparam logic [RUN_W-1:0] RUN_LAST = RUN_W'(ROW_CYCLES - 1);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYCLES - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_REQ - 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    GAP
  } state_t;

  state_t             state;
  logic [RUN_W-1:0]   run_cnt;
  logic [GAP_W-1:0]   gap_cnt;
  logic [ROWS_W-1:0]  rows;
  logic [IDX_W-1:0]   last_win;

  logic               found;
  logic [IDX_W-1:0]   win;
  logic [NUM_REQ-1:0] win_oh;
  logic [ROWS_W-1:0]  win_rows;
  logic               last_row;

  // Two passes give the rotated scan: first the indices above the last
  // winner, then wrap around to 0..last_win.
  always_comb begin
    found    = 1'b0;
    win      = last_win;
    win_oh   = '0;
    win_rows = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!found && req[i] && (IDX_W'(i) > last_win)) begin
        found = 1'b1;
        win   = IDX_W'(i);
      end
    end
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!found && req[i] && (IDX_W'(i) <= last_win)) begin
        found = 1'b1;
        win   = IDX_W'(i);
      end
    end
    for (int i = 0; i < NUM_REQ; i++) begin
      if (IDX_W'(i) == win) begin
        win_oh[i] = found;
        win_rows  = req_rows[i*ROWS_W +: ROWS_W];
      end
    end
  end

  // rows is never 0 outside IDLE, so rows-1 cannot wrap here.
  assign last_row = (row_idx == rows - ROWS_W'(1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      grant      <= '0;
      softmax_en <= 1'b0;
      row_start  <= 1'b0;
      row_done   <= 1'b0;
      row_idx    <= '0;
      job_done   <= '0;
      busy       <= 1'b0;
      run_cnt    <= '0;
      gap_cnt    <= '0;
      rows       <= '0;
      last_win   <= IDX_LAST;
    end else begin
      row_start <= 1'b0;
      row_done  <= 1'b0;
      job_done  <= '0;
      unique case (state)
        IDLE: begin
          if (found) begin
            last_win <= win;
            rows     <= win_rows;
            if (win_rows != '0) begin
              state      <= RUN;
              grant      <= win_oh;
              softmax_en <= 1'b1;
              row_start  <= 1'b1;
              busy       <= 1'b1;
              row_idx    <= '0;
              run_cnt    <= '0;
              // Single-cycle rows: first cycle is also the last.
              if (RUN_LAST == '0) begin
                row_done <= 1'b1;
                if (win_rows == ROWS_W'(1))
                  job_done <= win_oh;
              end
            end else begin
              job_done <= win_oh;
            end
          end
        end
        RUN: begin
          if (run_cnt == RUN_LAST) begin
            softmax_en <= 1'b0;
            run_cnt    <= '0;
            if (last_row) begin
              state   <= IDLE;
              grant   <= '0;
              row_idx <= '0;
              busy    <= 1'b0;
            end else begin
              state   <= GAP;
              gap_cnt <= '0;
              row_idx <= row_idx + ROWS_W'(1);
            end
          end else begin
            run_cnt <= run_cnt + RUN_W'(1);
            // Strobes are registered, so flag the upcoming last cycle.
            if (run_cnt + RUN_W'(1) == RUN_LAST) begin
              row_done <= 1'b1;
              if (last_row)
                job_done <= grant;
            end
          end
        end
        GAP: begin
          if (gap_cnt == GAP_LAST) begin
            state      <= RUN;
            softmax_en <= 1'b1;
            row_start  <= 1'b1;
            gap_cnt    <= '0;
            if (RUN_LAST == '0) begin
              row_done <= 1'b1;
              if (last_row)
                job_done <= grant;
            end
          end else begin
            gap_cnt <= gap_cnt + GAP_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_softmax_row_scheduler.sv
// Directed bench for softmax_row_scheduler.
// Cycle 0 is the cycle a request is applied; checks sample #1 after edges.
module tb_softmax_row_scheduler;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  req;
  logic [15:0] req_rows;
  logic [1:0]  grant;
  logic        softmax_en;
  logic        row_start;
  logic        row_done;
  logic [7:0]  row_idx;
  logic [1:0]  job_done;
  logic        busy;

  logic        rst2;
  logic [1:0]  req2;
  logic [15:0] rows2;
  logic [1:0]  grant2;
  logic        en2;
  logic        rs2;
  logic        rd2;
  logic [7:0]  idx2;
  logic [1:0]  jd2;
  logic        busy2;

  int checks = 0;
  int errors = 0;

  logic [1:0] e_gr;
  logic       e_en;
  logic       e_rs;
  logic       e_rd;
  logic [1:0] e_jd;
  logic       e_busy;
  logic [7:0] e_idx;

  always #5 clk = ~clk;

  softmax_row_scheduler dut (
    .clk(clk), .rst(rst), .req(req), .req_rows(req_rows),
    .grant(grant), .softmax_en(softmax_en),
    .row_start(row_start), .row_done(row_done),
    .row_idx(row_idx), .job_done(job_done), .busy(busy)
  );

  softmax_row_scheduler #(.GAP_CYCLES(3)) dut_gap3 (
    .clk(clk), .rst(rst2), .req(req2), .req_rows(rows2),
    .grant(grant2), .softmax_en(en2),
    .row_start(rs2), .row_done(rd2),
    .row_idx(idx2), .job_done(jd2), .busy(busy2)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req = 2'b00;
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst      = 1'b1;
    req      = 2'b11;
    req_rows = 16'h0303;
    rst2     = 1'b1;
    req2     = 2'b00;
    rows2    = 16'h0000;
    step();
    step();
    checks++;
    if ({grant, softmax_en, row_start, row_done, job_done, busy, row_idx}
        !== 15'h0) begin
      errors++;
      $display("FAIL reset_outputs got %h required 0",
        {grant, softmax_en, row_start, row_done, job_done, busy, row_idx});
    end
    req = 2'b00;
    rst = 1'b0;
    step();
    checks++;
    if ({grant, softmax_en, busy} !== 4'h0) begin
      errors++;
      $display("FAIL reset_idle got %h required 0",
        {grant, softmax_en, busy});
    end
  endtask

  task automatic test_single_job();
    do_reset();
    req      = 2'b01;
    req_rows = 16'h0003;
    for (int c = 1; c <= 81; c++) begin
      step();
      e_en = (c >= 1 && c <= 26) || (c >= 28 && c <= 53) ||
             (c >= 55 && c <= 80);
      e_rs = (c == 1) || (c == 28) || (c == 55);
      e_rd = (c == 26) || (c == 53) || (c == 80);
      e_jd = (c == 80) ? 2'b01 : 2'b00;
      e_gr = (c <= 80) ? 2'b01 : 2'b00;
      e_busy = (c <= 80);
      e_idx = (c <= 26) ? 8'd0 : (c <= 53) ? 8'd1 :
              (c <= 80) ? 8'd2 : 8'd0;
      checks++;
      if ({grant, softmax_en, row_start, row_done, job_done, busy, row_idx}
          !== {e_gr, e_en, e_rs, e_rd, e_jd, e_busy, e_idx}) begin
        errors++;
        $display("FAIL single_job c=%0d got %h required %h", c,
          {grant, softmax_en, row_start, row_done, job_done, busy, row_idx},
          {e_gr, e_en, e_rs, e_rd, e_jd, e_busy, e_idx});
      end
      if (c == 80) req = 2'b00;
    end
  endtask

  task automatic test_contention();
    do_reset();
    req      = 2'b11;
    req_rows = 16'h0101;
    for (int c = 1; c <= 55; c++) begin
      step();
      e_gr = (c <= 26) ? 2'b01 : (c == 27) ? 2'b00 :
             (c <= 53) ? 2'b10 : (c == 54) ? 2'b00 : 2'b01;
      e_jd = (c == 26) ? 2'b01 : (c == 53) ? 2'b10 : 2'b00;
      e_en = (c != 27) && (c != 54);
      checks++;
      if ({grant, job_done, softmax_en} !== {e_gr, e_jd, e_en}) begin
        errors++;
        $display("FAIL contention c=%0d got %h required %h", c,
          {grant, job_done, softmax_en}, {e_gr, e_jd, e_en});
      end
      if (c == 26) req[0] = 1'b0;
      if (c == 27) req[0] = 1'b1;
      if (c == 53) req[1] = 1'b0;
    end
    req = 2'b00;
  endtask

  task automatic test_zero_rows();
    do_reset();
    req      = 2'b10;
    req_rows = 16'h0000;
    step();
    checks++;
    if ({job_done, grant, softmax_en, busy} !== 6'b10_00_0_0) begin
      errors++;
      $display("FAIL zero_rows got %b required 100000",
        {job_done, grant, softmax_en, busy});
    end
    req      = 2'b11;
    req_rows = 16'h0101;
    step();
    checks++;
    if ({grant, softmax_en, row_start} !== 4'b01_1_1) begin
      errors++;
      $display("FAIL zero_rows_rr got %b required 0111",
        {grant, softmax_en, row_start});
    end
    req = 2'b00;
    for (int c = 3; c <= 28; c++) begin
      step();
      e_jd = (c == 27) ? 2'b01 : 2'b00;
      e_busy = (c <= 27);
      checks++;
      if ({job_done, busy} !== {e_jd, e_busy}) begin
        errors++;
        $display("FAIL zero_rows_tail c=%0d got %b required %b", c,
          {job_done, busy}, {e_jd, e_busy});
      end
    end
  endtask

  task automatic test_reset_mid_job();
    do_reset();
    req      = 2'b01;
    req_rows = 16'h0002;
    for (int c = 1; c <= 10; c++) step();
    checks++;
    if ({grant, softmax_en} !== 3'b01_1) begin
      errors++;
      $display("FAIL midjob_pre got %b required 011",
        {grant, softmax_en});
    end
    rst = 1'b1;
    req = 2'b00;
    step();
    rst = 1'b0;
    checks++;
    if ({grant, softmax_en, row_start, row_done, job_done, busy, row_idx}
        !== 15'h0) begin
      errors++;
      $display("FAIL midjob_abort got %h required 0",
        {grant, softmax_en, row_start, row_done, job_done, busy, row_idx});
    end
    step();
    checks++;
    if ({grant, softmax_en, job_done, busy} !== 6'h0) begin
      errors++;
      $display("FAIL midjob_idle got %h required 0",
        {grant, softmax_en, job_done, busy});
    end
    req = 2'b01;
    step();
    checks++;
    if ({grant, softmax_en, row_start, row_idx} !== {2'b01, 1'b1, 1'b1, 8'd0})
    begin
      errors++;
      $display("FAIL midjob_regrant got %h required %h",
        {grant, softmax_en, row_start, row_idx},
        {2'b01, 1'b1, 1'b1, 8'd0});
    end
    req = 2'b00;
  endtask

  task automatic test_req_drop();
    do_reset();
    req      = 2'b01;
    req_rows = 16'h0002;
    for (int c = 1; c <= 54; c++) begin
      step();
      if (c == 5) req = 2'b00;
      e_jd = (c == 53) ? 2'b01 : 2'b00;
      e_en = (c <= 26) || (c >= 28 && c <= 53);
      e_busy = (c <= 53);
      checks++;
      if ({job_done, softmax_en, busy} !== {e_jd, e_en, e_busy}) begin
        errors++;
        $display("FAIL req_drop c=%0d got %b required %b", c,
          {job_done, softmax_en, busy}, {e_jd, e_en, e_busy});
      end
    end
  endtask

  task automatic test_gap3();
    rst2 = 1'b1;
    step();
    rst2  = 1'b0;
    req2  = 2'b01;
    rows2 = 16'h0002;
    for (int c = 1; c <= 56; c++) begin
      step();
      if (c == 1) req2 = 2'b00;
      e_en = (c <= 26) || (c >= 30 && c <= 55);
      e_rs = (c == 1) || (c == 30);
      e_rd = (c == 26) || (c == 55);
      e_jd = (c == 55) ? 2'b01 : 2'b00;
      e_gr = (c <= 55) ? 2'b01 : 2'b00;
      e_idx = (c >= 27 && c <= 55) ? 8'd1 : 8'd0;
      checks++;
      if ({grant2, en2, rs2, rd2, jd2, idx2}
          !== {e_gr, e_en, e_rs, e_rd, e_jd, e_idx}) begin
        errors++;
        $display("FAIL gap3 c=%0d got %h required %h", c,
          {grant2, en2, rs2, rd2, jd2, idx2},
          {e_gr, e_en, e_rs, e_rd, e_jd, e_idx});
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_job();
    test_contention();
    test_zero_rows();
    test_reset_mid_job();
    test_req_drop();
    test_gap3();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
